// File: rtl/fp_to_int.sv
// IEEE-754 single to int32 (round toward zero) via an iterative barrel-step shifter; 2+ceil(n/SHIFT_STEP) edges
// from accept to out_valid. One operation in flight; in_ready drops until the result is taken, out_data held under backpressure.
module fp_to_int #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SHIFT,
        S_FINISH,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] opnd_q;
    logic [31:0] acc_q;
    logic [4:0]  rem_q;
    logic        left_q;
    logic        neg_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        invalid_q;
    logic        inexact_q;

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] frac;
    logic [4:0]  lsh_n;
    logic [4:0]  rsh_n;
    logic [4:0]  step;
    logic [31:0] shr_mask;
    logic [31:0] acc_d;
    logic        lost_d;

    assign sign = opnd_q[31];
    assign expo = opnd_q[30:23];
    assign frac = opnd_q[22:0];

    // Shift distances relative to E=150 (e=23); only the low 5 bits matter since |e-23| <= 23.
    assign lsh_n = expo[4:0] - 5'd22;
    assign rsh_n = 5'd22 - expo[4:0];

    always_comb begin
        step     = (rem_q < STEP) ? rem_q : STEP;
        shr_mask = (32'd1 << step) - 32'd1;
        acc_d    = left_q ? (acc_q << step) : (acc_q >> step);
        lost_d   = !left_q && ((acc_q & shr_mask) != 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opnd_q      <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            left_q      <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (in_valid) begin
                        opnd_q     <= in_data;
                        in_ready_q <= 1'b0;
                        acc_q      <= '0;
                        rem_q      <= '0;
                        left_q     <= 1'b0;
                        neg_q      <= 1'b0;
                        invalid_q  <= 1'b0;
                        inexact_q  <= 1'b0;
                        state_q    <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    state_q <= S_FINISH;
                    if (expo == 8'd255) begin
                        invalid_q <= 1'b1;
                        if (frac != 23'd0)
                            acc_q <= 32'h7FFF_FFFF;
                        else
                            acc_q <= sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end else if (expo == 8'd0) begin
                        inexact_q <= (frac != 23'd0);
                    end else if (expo < 8'd127) begin
                        inexact_q <= 1'b1;
                    end else if (expo >= 8'd158) begin
                        // -2^31 is the one representable value in this range.
                        acc_q     <= sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        invalid_q <= !(sign && expo == 8'd158 && frac == 23'd0);
                    end else begin
                        acc_q <= {8'd0, 1'b1, frac};
                        neg_q <= sign;
                        if (expo > 8'd150) begin
                            left_q  <= 1'b1;
                            rem_q   <= lsh_n;
                            state_q <= S_SHIFT;
                        end else if (expo < 8'd150) begin
                            left_q  <= 1'b0;
                            rem_q   <= rsh_n;
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q     <= acc_d;
                    inexact_q <= inexact_q | lost_d;
                    rem_q     <= rem_q - step;
                    if (rem_q == step)
                        state_q <= S_FINISH;
                end
                S_FINISH: begin
                    out_data_q  <= neg_q ? (~acc_q + 32'd1) : acc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule
